naive_bus_timer_slave: RTL

//   Memory-mapped 64-bit machine timer that sits on the slave (responder) side of naive_bus.
//   The data-bus arbiter routes the core's data_master to this block.
//   It answers rd/wr requests with a fixed 1-cycle read latency.
//   It provides mtime and mtimecmp, a prescaler, and a level interrupt to the core.

---
 rtl/naive_bus_timer_slave_if.sv | 28 ++
 rtl/naive_bus_timer_slave.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/naive_bus_timer_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : naive_bus_timer_slave_if
// Description : naive_bus read/write channel bundle with master/slave views.
// Revision    : 1.0
// ============================================================================
interface naive_bus_timer_slave_if;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_byte;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_byte, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_byte, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface
`default_nettype wire

// File: rtl/naive_bus_timer_slave.sv
`default_nettype none
// ============================================================================
// Module      : naive_bus_timer_slave
// Description : 64-bit memory-mapped machine timer (mtime/mtimecmp) with
//               prescaler and level interrupt, on the slave side of naive_bus.
// Revision    : 1.0
// ============================================================================
module naive_bus_timer_slave #(
  parameter int          PRE_W   = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  wire logic                clk,
  input  wire logic                rst,
  naive_bus_timer_slave_if.slave   bus,
  output      logic                o_irq
);

  localparam logic [2:0] c_MTIME_LO = 3'd0;
  localparam logic [2:0] c_MTIME_HI = 3'd1;
  localparam logic [2:0] c_CMP_LO   = 3'd2;
  localparam logic [2:0] c_CMP_HI   = 3'd3;
  localparam logic [2:0] c_CTRL     = 3'd4;
  localparam logic [2:0] c_PRESCALE = 3'd5;
  localparam logic [2:0] c_STATUS   = 3'd6;

  logic [63:0]      r_mtime;
  logic [63:0]      r_cmp;
  logic [31:0]      r_shadow;
  logic [31:0]      r_rd_data;
  logic [PRE_W-1:0] r_prescale;
  logic [PRE_W-1:0] r_pcnt;
  logic             r_en;
  logic             r_irq_en;
  logic             r_pending;

  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_wsel;
  logic [2:0]       w_rsel;
  logic             w_tick;
  logic             w_set;
  logic             w_clr;
  logic [31:0]      w_rd_mux;
  logic [31:0]      w_mlo_m;
  logic [31:0]      w_mhi_m;
  logic [31:0]      w_clo_m;
  logic [31:0]      w_chi_m;
  logic [31:0]      w_ctrl_m;
  logic [31:0]      w_pre_m;
  logic             w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = din[8*i +: 8];
    end
    return res;
  endfunction

  assign w_wr   = bus.wr_req;
  assign w_rd   = bus.rd_req & ~bus.wr_req;
  assign w_wsel = bus.wr_addr[4:2];
  assign w_rsel = bus.rd_addr[4:2];

  assign bus.wr_gnt  = w_wr;
  assign bus.rd_gnt  = w_rd;
  assign bus.rd_data = r_rd_data;
  assign o_irq       = r_pending & r_irq_en;

  assign w_mlo_m  = f_merge(r_mtime[31:0],  bus.wr_data, bus.wr_byte);
  assign w_mhi_m  = f_merge(r_mtime[63:32], bus.wr_data, bus.wr_byte);
  assign w_clo_m  = f_merge(r_cmp[31:0],    bus.wr_data, bus.wr_byte);
  assign w_chi_m  = f_merge(r_cmp[63:32],   bus.wr_data, bus.wr_byte);
  assign w_ctrl_m = f_merge({30'd0, r_irq_en, r_en}, bus.wr_data, bus.wr_byte);
  assign w_pre_m  = f_merge(32'(r_prescale), bus.wr_data, bus.wr_byte);

  // >= rather than == so lowering PRESCALE below a running pcnt ticks at once instead of wrapping
  assign w_tick = r_en & (r_pcnt >= r_prescale);
  assign w_set  = r_en & (r_mtime >= r_cmp);
  assign w_clr  = w_wr & (w_wsel == c_STATUS) & bus.wr_byte[0] & bus.wr_data[0];

  assign w_unused = ^{bus.rd_addr[31:5], bus.rd_addr[1:0], bus.wr_addr[31:5],
                      bus.wr_addr[1:0], w_ctrl_m, w_pre_m};

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_rsel)
      c_MTIME_LO: w_rd_mux = r_mtime[31:0];
      c_MTIME_HI: w_rd_mux = r_shadow;
      c_CMP_LO:   w_rd_mux = r_cmp[31:0];
      c_CMP_HI:   w_rd_mux = r_cmp[63:32];
      c_CTRL:     w_rd_mux = {30'd0, r_irq_en, r_en};
      c_PRESCALE: w_rd_mux = 32'(r_prescale);
      c_STATUS:   w_rd_mux = {31'd0, r_pending};
      default:    w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= 64'd0;
      r_cmp      <= CMP_RST;
      r_shadow   <= 32'd0;
      r_rd_data  <= 32'd0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      // A write to either mtime half suppresses that cycle's increment entirely
      if (w_wr && w_wsel == c_MTIME_LO) begin
        r_mtime[31:0] <= w_mlo_m;
      end else if (w_wr && w_wsel == c_MTIME_HI) begin
        r_mtime[63:32] <= w_mhi_m;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (r_en) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + PRE_W'(1);
      end

      if (w_wr) begin
        case (w_wsel)
          c_CMP_LO:   r_cmp[31:0]  <= w_clo_m;
          c_CMP_HI:   r_cmp[63:32] <= w_chi_m;
          c_CTRL: begin
            r_en     <= w_ctrl_m[0];
            r_irq_en <= w_ctrl_m[1];
          end
          c_PRESCALE: r_prescale <= w_pre_m[PRE_W-1:0];
          default: ;
        endcase
      end

      if (w_set) begin
        r_pending <= 1'b1;
      end else if (w_clr) begin
        r_pending <= 1'b0;
      end

      if (w_rd) begin
        r_rd_data <= w_rd_mux;
        if (w_rsel == c_MTIME_LO) r_shadow <= r_mtime[63:32];
      end
    end
  end

endmodule
`default_nettype wire
